// File: rtl/funct_reader_pkg.sv
// Shared definitions for the function-generator sample reader.
//   state_e       : reader FSM state encoding
//   DIV_WIDTH_DEF : default width of the sample-period divider
//   MIN_DIV_DEF   : default smallest legal sample period in clocks
package funct_reader_pkg;

    localparam int DIV_WIDTH_DEF = 16;
    localparam int MIN_DIV_DEF   = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        READ = 3'd2,
        LOAD = 3'd3,
        OUT  = 3'd4
    } state_e;

endpackage

// File: rtl/funct_reader_tick.sv
// Sample-period tick generator: a reload down-counter.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   load     : hold the counter at div_reg-1 (reader idle)
//   div_reg  : period in clocks (already clamped by the caller)
//   tick     : high for one clock every div_reg clocks while not loading
module funct_reader_tick
    import funct_reader_pkg::*;
#(
    parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] div_reg,
    output logic                 tick
);

    localparam logic [DIV_WIDTH-1:0] ZERO = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    logic [DIV_WIDTH-1:0] cnt_r;

    // The counter sitting at 0 in idle right after reset must not look like a tick.
    assign tick = (!load) && (cnt_r == ZERO);

    // Down-counter: reload on load or on reaching zero, else decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= ZERO;
        end else if (load || (cnt_r == ZERO)) begin
            cnt_r <= div_reg - ONE;
        end else begin
            cnt_r <= cnt_r - ONE;
        end
    end

endmodule

// File: rtl/funct_sample_reader.sv
// Read-side consumer of the function-generator sample FIFO. Pops one sample
// per programmable period and presents it on a valid/ready stream.
// Optional feature macro: FUNCT_READER_CNT_EN (delivered-sample counter).
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   enh_i            : run enable (level)
//   div_i            : sample period, latched on IDLE->WAIT, clamped to MIN_DIV
//   clr_flags_i      : clear sticky flags (and sample counter)
//   fifo_empty_i     : FIFO empty flag
//   fifo_rd_en_o     : one-cycle FIFO pop strobe
//   fifo_data_i      : FIFO data, valid one clock after the pop
//   data_o, valid_o  : output sample stream, ready_i accepts
//   underrun_o       : sticky, tick with FIFO empty
//   late_o           : sticky, tick while previous sample still pending
//   sample_cnt_o     : handshake count (zero when the feature is off)
module funct_sample_reader
    import funct_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_WIDTH  = DIV_WIDTH_DEF,
    parameter int MIN_DIV    = MIN_DIV_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enh_i,
    input  logic [DIV_WIDTH-1:0]  div_i,
    input  logic                  clr_flags_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  underrun_o,
    output logic                  late_o,
    output logic [31:0]           sample_cnt_o
);

    localparam logic [DIV_WIDTH-1:0] MIN_DIV_L = DIV_WIDTH'(MIN_DIV);

    function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
        return (d < MIN_DIV_L) ? MIN_DIV_L : d;
    endfunction

    state_e                state_r;
    logic [DIV_WIDTH-1:0]  div_reg_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  valid_r;
    logic                  rd_en_r;
    logic                  underrun_r;
    logic                  late_r;

    logic                  idle_s;
    logic [DIV_WIDTH-1:0]  div_sel_s;
    logic                  tick_s;
    logic                  underrun_set_s;
    logic                  late_set_s;

    // In idle the counter preloads from the clamped div_i, so the first WAIT
    // period already uses the period being latched on the same edge.
    always_comb begin
        idle_s         = 1'b0;
        div_sel_s      = div_reg_r;
        underrun_set_s = 1'b0;
        late_set_s     = 1'b0;
        if (state_r == IDLE) begin
            idle_s    = 1'b1;
            div_sel_s = clamp_div(div_i);
        end else begin
            idle_s    = 1'b0;
            div_sel_s = div_reg_r;
        end
        // Disable wins over a tick in WAIT, so no underrun on that cycle.
        if ((state_r == WAIT) && enh_i && tick_s && fifo_empty_i) begin
            underrun_set_s = 1'b1;
        end else begin
            underrun_set_s = 1'b0;
        end
        if ((state_r == OUT) && tick_s) begin
            late_set_s = 1'b1;
        end else begin
            late_set_s = 1'b0;
        end
    end

    funct_reader_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .load    (idle_s),
        .div_reg (div_sel_s),
        .tick    (tick_s)
    );

    // Reader FSM with registered stream outputs and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            div_reg_r  <= MIN_DIV_L;
            data_r     <= {DATA_WIDTH{1'b0}};
            valid_r    <= 1'b0;
            rd_en_r    <= 1'b0;
            underrun_r <= 1'b0;
            late_r     <= 1'b0;
        end else begin
            rd_en_r <= 1'b0;
            // A set event in the same cycle beats the clear request.
            underrun_r <= underrun_set_s ? 1'b1 : (clr_flags_i ? 1'b0 : underrun_r);
            late_r     <= late_set_s     ? 1'b1 : (clr_flags_i ? 1'b0 : late_r);
            case (state_r)
                IDLE: begin
                    if (enh_i) begin
                        state_r   <= WAIT;
                        div_reg_r <= clamp_div(div_i);
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    if (!enh_i) begin
                        state_r <= IDLE;
                    end else if (tick_s && !fifo_empty_i) begin
                        state_r <= READ;
                        rd_en_r <= 1'b1;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                READ: begin
                    state_r <= LOAD;
                end
                LOAD: begin
                    data_r  <= fifo_data_i;
                    valid_r <= 1'b1;
                    state_r <= OUT;
                end
                OUT: begin
                    if (ready_i) begin
                        valid_r <= 1'b0;
                        state_r <= enh_i ? WAIT : IDLE;
                    end else begin
                        state_r <= OUT;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en_o = rd_en_r;
    assign data_o       = data_r;
    assign valid_o      = valid_r;
    assign underrun_o   = underrun_r;
    assign late_o       = late_r;

`ifdef FUNCT_READER_CNT_EN
    logic [31:0] cnt_r;
    logic        hs_s;

    assign hs_s = valid_r && ready_i;

    // Handshake counter; an increment concurrent with a clear restarts at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 32'd0;
        end else if (hs_s) begin
            cnt_r <= clr_flags_i ? 32'd1 : (cnt_r + 32'd1);
        end else if (clr_flags_i) begin
            cnt_r <= 32'd0;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign sample_cnt_o = cnt_r;
`else
    assign sample_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_funct_sample_reader.sv
// Directed bench for funct_sample_reader with a FIFO model and an
// expected-sample scoreboard.
module tb_funct_sample_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        enh_i;
    logic [15:0] div_i;
    logic        clr_flags_i;
    logic        fifo_empty_i;
    logic        fifo_rd_en_o;
    logic [31:0] fifo_data_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        underrun_o;
    logic        late_o;
    logic [31:0] sample_cnt_o;

    always #5 clk = ~clk;

    funct_sample_reader dut (
        .clk          (clk),
        .rst          (rst),
        .enh_i        (enh_i),
        .div_i        (div_i),
        .clr_flags_i  (clr_flags_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rd_en_o (fifo_rd_en_o),
        .fifo_data_i  (fifo_data_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .underrun_o   (underrun_o),
        .late_o       (late_o),
        .sample_cnt_o (sample_cnt_o)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    int          pop_q[$];
    int          cyc_n = 0;
    int          hs_cnt = 0;
    int          last_rise = -1;
    logic        prev_valid = 1'b0;
    logic [31:0] exp_cnt = 32'd0;
    int          c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [31:0] v);
        fifo_q.push_back(v);
        exp_q.push_back(v);
        fifo_empty_i = 1'b0;
    endtask

    // One clock: observe the current cycle, advance, then update the FIFO model.
    task automatic cyc();
        logic pop_now, hs_now, clr_now, rst_now;
        pop_now = fifo_rd_en_o;
        hs_now  = valid_o && ready_i;
        clr_now = clr_flags_i;
        rst_now = rst;
        if (valid_o && !prev_valid) last_rise = cyc_n;
        prev_valid = valid_o;
        if (pop_now) pop_q.push_back(cyc_n);
        if (hs_now && !rst_now) begin
            chk("sb_nonempty", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() != 0) chk("sb_data", data_o, exp_q.pop_front());
            hs_cnt++;
        end
`ifdef FUNCT_READER_CNT_EN
        if (rst_now) exp_cnt = 32'd0;
        else if (hs_now) exp_cnt = clr_now ? 32'd1 : exp_cnt + 32'd1;
        else if (clr_now) exp_cnt = 32'd0;
`endif
        @(posedge clk);
        #1;
        cyc_n++;
        if (pop_now) begin
            chk("pop_nonempty", (fifo_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (fifo_q.size() != 0) fifo_data_i = fifo_q.pop_front();
        end
        fifo_empty_i = (fifo_q.size() == 0);
    endtask

    task automatic run_hs(input int target, input string tag);
        int k = 0;
        while (hs_cnt < target && k < 200) begin cyc(); k++; end
        chk(tag, hs_cnt, target);
    endtask

    task automatic run_valid(input string tag);
        int k = 0;
        while (!valid_o && k < 200) begin cyc(); k++; end
        chk(tag, {31'd0, valid_o}, 32'd1);
    endtask

    task automatic run_pop(input string tag);
        int k = 0;
        while (!fifo_rd_en_o && k < 200) begin cyc(); k++; end
        chk(tag, {31'd0, fifo_rd_en_o}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; enh_i = 1'b0; div_i = 16'd8; clr_flags_i = 1'b0;
        fifo_empty_i = 1'b1; fifo_data_i = 32'd0; ready_i = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_rd_en", {31'd0, fifo_rd_en_o}, 32'd0);
        chk("rst_underrun", {31'd0, underrun_o}, 32'd0);
        chk("rst_late", {31'd0, late_o}, 32'd0);
        chk("rst_data", data_o, 32'd0);
        chk("rst_cnt", sample_cnt_o, 32'd0);

        // Steady stream, period 8
        push(32'h1000_0000); push(32'h2000_0000); push(32'h3000_0000);
        pop_q.delete();
        enh_i = 1'b1; c = cyc_n;
        run_hs(3, "t1_hs");
        chk("t1_pops", pop_q.size(), 3);
        chk("t1_first_pop", pop_q[0], c + 9);
        chk("t1_gap1", pop_q[1] - pop_q[0], 8);
        chk("t1_gap2", pop_q[2] - pop_q[1], 8);
        chk("t1_latency", last_rise - pop_q[2], 2);
        enh_i = 1'b0;
        cyc();
        chk("t1_underrun", {31'd0, underrun_o}, 32'd0);
        chk("t1_late", {31'd0, late_o}, 32'd0);
        chk("t1_cnt", sample_cnt_o, exp_cnt);

        // Clamp and underrun, div_i=1 -> period 4
        div_i = 16'd1; pop_q.delete();
        enh_i = 1'b1; c = cyc_n;
        repeat (4) cyc();
        chk("t2_underrun_pre", {31'd0, underrun_o}, 32'd0);
        cyc();
        chk("t2_underrun_set", {31'd0, underrun_o}, 32'd1);
        clr_flags_i = 1'b1; cyc(); clr_flags_i = 1'b0;
        chk("t2_clr", {31'd0, underrun_o}, 32'd0);
        push(32'hA5A5_0001);
        run_hs(4, "t2_hs");
        chk("t2_pop_at", pop_q[0], c + 9);
        clr_flags_i = 1'b1; cyc(); clr_flags_i = 1'b0;
        chk("t2_set_over_clr", {31'd0, underrun_o}, 32'd1);
        enh_i = 1'b0; clr_flags_i = 1'b1; cyc(); clr_flags_i = 1'b0;
        chk("t2_clr2", {31'd0, underrun_o}, 32'd0);
        chk("t2_pops", pop_q.size(), 1);

        // Backpressure, period 5, ready low for 12 clocks
        div_i = 16'd5; ready_i = 1'b0; pop_q.delete();
        push(32'h1234_5678); push(32'h8765_4321);
        enh_i = 1'b1; c = cyc_n;
        run_valid("t3_valid");
        chk("t3_valid_at", cyc_n, c + 8);
        for (int i = 0; i < 12; i++) begin
            chk("t3_valid_hold", {31'd0, valid_o}, 32'd1);
            chk("t3_data_hold", data_o, exp_q[0]);
            if (i == 2) chk("t3_late_pre", {31'd0, late_o}, 32'd0);
            if (i == 3) chk("t3_late_set", {31'd0, late_o}, 32'd1);
            cyc();
        end
        ready_i = 1'b1; clr_flags_i = 1'b1; cyc(); clr_flags_i = 1'b0;
        chk("t3_late_over_clr", {31'd0, late_o}, 32'd1);
        chk("t3_cnt_clr_hs", sample_cnt_o, exp_cnt);
        run_hs(6, "t3_hs");
        chk("t3_pops", pop_q.size(), 2);
        chk("t3_next_pop", pop_q[1], c + 26);
        enh_i = 1'b0; clr_flags_i = 1'b1; cyc(); clr_flags_i = 1'b0;
        chk("t3_late_clr", {31'd0, late_o}, 32'd0);
        chk("t3_no_lost", exp_q.size(), 0);

        // Disable during READ, then re-enable with period 6
        div_i = 16'd4; pop_q.delete();
        push(32'h0BAD_F00D);
        enh_i = 1'b1;
        run_pop("t4_pop");
        enh_i = 1'b0;
        run_hs(7, "t4_hs");
        push(32'h600D_0006);
        repeat (10) cyc();
        chk("t4_no_pop", pop_q.size(), 1);
        div_i = 16'd6; enh_i = 1'b1; c = cyc_n;
        run_hs(8, "t4_hs2");
        chk("t4_new_period", pop_q[1], c + 7);
        enh_i = 1'b0; cyc();
        chk("t4_cnt", sample_cnt_o, exp_cnt);

        // Reset while OUT with valid high and late set
        div_i = 16'd4; ready_i = 1'b0;
        push(32'h5EED_0005);
        enh_i = 1'b1;
        run_valid("t5_valid");
        repeat (5) cyc();
        chk("t5_late_pre", {31'd0, late_o}, 32'd1);
        rst = 1'b1; enh_i = 1'b0; cyc(); rst = 1'b0;
        exp_q.delete();
        chk("t5_valid", {31'd0, valid_o}, 32'd0);
        chk("t5_rd_en", {31'd0, fifo_rd_en_o}, 32'd0);
        chk("t5_underrun", {31'd0, underrun_o}, 32'd0);
        chk("t5_late", {31'd0, late_o}, 32'd0);
        chk("t5_cnt", sample_cnt_o, 32'd0);
        repeat (3) cyc();
        chk("t5_idle_valid", {31'd0, valid_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/funct_sample_reader.md
Name: funct_sample_reader

Overview:
- Consumer at the read end of the sample FIFO that the function generator fills.
- Pops one sample per programmable sample period and presents it on a valid/ready output stream toward the DAC/serializer.
- Flags FIFO underrun and late-consumer conditions with sticky flags.
- Control is a single FSM; period timing comes from a reload down-counter.

Parameters:
- DATA_WIDTH, 32: sample width, signed fixed-point, passed through unmodified.
- DIV_WIDTH, 16: width of the sample-period divider.
- MIN_DIV, 4: smallest legal period in clocks; smaller div_i values are clamped up to this.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enh_i  in  1  run enable; level-sensitive.
- div_i  in  DIV_WIDTH  sample period in clocks; sampled only on IDLE->WAIT.
- clr_flags_i  in  1  synchronous clear of underrun_o and late_o.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_rd_en_o  out  1  FIFO pop strobe, one cycle wide.
- fifo_data_i  in  DATA_WIDTH  FIFO read data, valid exactly one clock after fifo_rd_en_o.
- data_o  out  DATA_WIDTH  output sample.
- valid_o  out  1  data_o valid.
- ready_i  in  1  downstream accept.
- underrun_o  out  1  sticky flag: period tick arrived with the FIFO empty.
- late_o  out  1  sticky flag: period tick arrived while the previous sample was not yet accepted.
- sample_cnt_o  out  32  delivered-sample count (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; all outputs 0; div_reg=MIN_DIV; tick counter=0.
  - Any popped-but-undelivered sample is discarded.
- Period latch: div_reg = max(div_i, MIN_DIV), latched on IDLE->WAIT.
- Tick counter:
  - Held at div_reg-1 in IDLE.
  - Otherwise decrements every clock; tick=1 when it equals 0, and it reloads div_reg-1 on that same clock.
  - Tick period is exactly div_reg clocks, free-running and independent of handshakes.
- FSM states: IDLE, WAIT, READ, LOAD, OUT.
  - IDLE: on enh_i=1 -> WAIT.
  - WAIT:
    - enh_i=0 -> IDLE; this takes priority over a tick in the same cycle.
    - tick with fifo_empty_i=0 -> READ.
    - tick with fifo_empty_i=1 -> set underrun_o, stay in WAIT; no pop.
  - READ: fifo_rd_en_o=1 for this cycle only -> LOAD. enh_i is ignored.
  - LOAD: data_o <= fifo_data_i, valid_o <= 1 -> OUT. enh_i is ignored.
  - OUT:
    - valid_o held, data_o stable until valid_o and ready_i are both 1.
    - On that handshake: valid_o <= 0, then -> WAIT if enh_i=1, else -> IDLE.
    - A tick while in OUT sets late_o; the tick is dropped, not queued.
- Ticks in READ or LOAD cannot occur because MIN_DIV >= 4.
- Pop-to-valid latency: 2 clocks from the tick edge (READ, LOAD); valid_o rises on the 2nd edge after the tick.
- Once a pop is issued, the sample is always delivered, even if enh_i drops.
- Flag update:
  - A set event overrides clr_flags_i in the same cycle.
  - Otherwise clr_flags_i=1 clears both flags on the next edge.
- data_o keeps its last value after the handshake; it is meaningful only while valid_o=1.
- fifo_rd_en_o is never asserted while fifo_empty_i was 1 at the deciding tick.

Optional Feature:
- FUNCT_READER_CNT_EN defined:
  - sample_cnt_o is a 32-bit counter incremented on each valid_o and ready_i handshake.
  - Wraps 0xFFFFFFFF -> 0.
  - Cleared by rst and by clr_flags_i; an increment in the same cycle as clr_flags_i wins, giving a value of 1.
- Not defined: sample_cnt_o tied to 0 and no counter flops are inferred.

Decomposition:
- Package funct_reader_pkg: state_e enum (IDLE, WAIT, READ, LOAD, OUT), MIN_DIV default, DIV_WIDTH default.
- Sub-module funct_reader_tick:
  - Inputs: clk, rst, load (IDLE), div_reg.
  - Output: tick, a reload down-counter.
  - The FSM, data register and flags stay in the top module.

Test Plan:
- Steady stream:
  - Setup: div_i=8, FIFO preloaded with 0x10000000, 0x20000000, 0x30000000; ready_i=1.
  - Expect: pops exactly 8 clocks apart; values delivered in order; valid_o rises 2 clocks after each tick; underrun_o=0, late_o=0.
- Clamp and underrun:
  - Setup: div_i=1, FIFO empty.
  - Expect: ticks every 4 clocks; underrun_o=1 after the first tick; fifo_rd_en_o never asserted; clr_flags_i pulse clears the flag.
- Backpressure:
  - Setup: div_i=5, ready_i=0 for 12 clocks.
  - Expect: data_o and valid_o stable throughout; late_o=1 on the first tick in OUT; next pop only on the first tick after the handshake; no lost or duplicate samples.
- Disable mid-operation:
  - Setup: drop enh_i in the READ cycle.
  - Expect: the popped sample still reaches OUT; after the handshake -> IDLE; no further pops; re-enabling with div_i=6 uses the new period.
- Reset mid-operation:
  - Setup: assert rst for 1 clock while in OUT with valid_o=1.
  - Expect: next edge valid_o=0, fifo_rd_en_o=0, flags=0, sample_cnt_o=0, state IDLE.
- With FUNCT_READER_CNT_EN: 5 handshakes -> sample_cnt_o=5; clr_flags_i concurrent with a handshake -> 1.
